ordered_xchg_bank: RTL and testbench
====================================

// Module: ordered_xchg_bank
// PURPOSE
//  Parametrised N-channel register bank with race-free, deterministic cross-channel
//  exchange. Each channel reg reads a neighbour's value. All channels update
//  simultaneously on the clock edge, so the result never depends on statement or
//  process ordering. It replaces the 2-channel ad-hoc a/b/c/d cross-copy, and adds
//  load, multi-step exchange, a mode select and a start/busy/done handshake.
// PARAMETERS
//  W      1  bits per channel
//  N      4  channel count; must be >= 2
//  STEPS  1  exchange steps per operation; must be >= 1
//  CW     $clog2(STEPS+1)  step-counter width (derived; do not override)
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    async reset, active-high
//  start      in   1    request an operation; sampled only in IDLE
//  mode       in   1    0 = rotate, 1 = pair-swap; captured with start
//  load_data  in   N*W  initial channel values; ch i = [i*W +: W]; captured with start
//  busy       out  1    high while in XCHG
//  done       out  1    one-cycle pulse when the operation completes
//  q          out  N*W  current channel registers; same packing as load_data
// BEHAVIOUR
//  - Reset: async on rst rising edge. While rst=1: state=IDLE, q=0, busy=0,
//    done=0, step counter=0, mode_r=0. This also applies mid-operation; the op is aborted.
//  - States: IDLE, XCHG, DONE.
//  - IDLE: if start=1 at an edge: q <= load_data, mode_r <= mode, cnt <= 0, go to XCHG.
//    If start=0: hold q.
//  - XCHG: busy=1. Each edge performs one step:
//    - mode_r=0 (rotate): ch[i] <= ch[(i+1) mod N], for all i at once.
//    - mode_r=1 (pair-swap): ch[2k] <=> ch[2k+1]. When N is odd, ch[N-1] holds.
//    - cnt increments each step. On the edge performing step STEPS, go to DONE.
//  - DONE: done=1, busy=0, q holds. Next edge goes to IDLE unconditionally.
//  - start is ignored in XCHG and DONE; there is no queueing. start in the IDLE
//    cycle after DONE is accepted.
//  - Latency: start accepted at edge E; q holds the final result after edge
//    E+STEPS; done is high during the cycle after edge E+STEPS.
//  - Back-to-back throughput: one operation per STEPS+2 cycles.
//  - busy and done are registered and never high together.
//  - Reads within a step see only pre-edge values (nonblocking only).
//    No #0 and no blocking cross-channel assignment.
//  - q is a direct register output with no combinational path from the inputs.
// CONFIGURATION
//  XCHG_SNAPSHOT_EN
//   - Defined: adds output port snap [N*W]. snap <= load_data on start acceptance
//     and holds through XCHG/DONE/IDLE until the next accepted start.
//     snap is reset to 0.
//   - Undefined: port snap and its register are absent. All other behaviour is identical.
// TESTING
//  1 Reset mid-XCHG (N=4, W=1, STEPS=3): assert rst in cycle 2 of XCHG
//    -> q=0000, busy=0, done=0 immediately (async), state IDLE after release.
//  2 Rotate (N=4, W=1, STEPS=1, mode=0): load_data=4'b0001
//    -> q=4'b1000 after 1 step; done pulses exactly 1 cycle; busy high for exactly 1 cycle.
//  3 Pair-swap, odd N (N=3, W=2, STEPS=1, mode=1): load {ch2,ch1,ch0}={3,2,1}
//    -> q={3,1,2}; ch2 unchanged.
//  4 Multi-step wrap (N=4, W=4, STEPS=4, mode=0): load {ch3..ch0}={D,C,B,A}
//    -> q={D,C,B,A} after 4 steps (full wrap); done at start-edge+4.
//  5 start asserted continuously for 12 cycles (STEPS=2)
//    -> ops accepted every 4 cycles; no start is accepted while busy or done is high.
//  6 XCHG_SNAPSHOT_EN defined, test 2 stimulus
//    -> snap=4'b0001 from acceptance onward; q as in test 2; snap=0 after reset.

Source files
------------

// File: rtl/ordered_xchg_bank.sv
// N-channel register bank with deterministic rotate / pair-swap exchange and a start/busy/done handshake.
// Optional macro XCHG_SNAPSHOT_EN adds a snap output that holds the last accepted load_data.
module ordered_xchg_bank #(
    parameter int W     = 1,
    parameter int N     = 4,
    parameter int STEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [N*W-1:0]   load_data,
    output logic             busy,
    output logic             done,
    output logic [N*W-1:0]   q
`ifdef XCHG_SNAPSHOT_EN
    ,
    output logic [N*W-1:0]   snap
`endif
);

    localparam int CW = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XCHG = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_cnt;
    logic             r_mode;
    logic [N*W-1:0]   r_q;
    logic             r_busy;
    logic             r_done;
    logic [N*W-1:0]   w_rot;
    logic [N*W-1:0]   w_swap;
    logic             w_cnt_last;

    // Both exchange results are pure functions of the pre-edge register image.
    for (genvar i = 0; i < N; i++) begin : g_xchg
        assign w_rot[i*W +: W] = r_q[((i + 1) % N)*W +: W];

        if ((i % 2) == 0 && (i + 1) < N) begin : g_even
            assign w_swap[i*W +: W] = r_q[(i + 1)*W +: W];
        end else if ((i % 2) == 1) begin : g_odd
            assign w_swap[i*W +: W] = r_q[(i - 1)*W +: W];
        end else begin : g_hold
            assign w_swap[i*W +: W] = r_q[i*W +: W];
        end
    end

    assign w_cnt_last = (r_cnt == CW'(STEPS - 1));

    // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_XCHG;
            S_XCHG:  if (w_cnt_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == S_XCHG);
            r_done  <= (w_next_state == S_DONE);
        end
    end

    // NOTE: every channel uses <=, so all channels read pre-edge values and update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            r_mode <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_q    <= load_data;
                        r_mode <= mode;
                        r_cnt  <= '0;
                    end
                end
                S_XCHG: begin
                    r_q   <= r_mode ? w_swap : w_rot;
                    r_cnt <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef XCHG_SNAPSHOT_EN
    logic [N*W-1:0] r_snap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_snap <= load_data;
        end
    end

    assign snap = r_snap;
`endif

    assign q    = r_q;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_ordered_xchg_bank.sv
// Directed bench for ordered_xchg_bank: several parameterisations share one clock and reset.
// Snap checks are compiled in only when XCHG_SNAPSHOT_EN is defined.
module tb_ordered_xchg_bank;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    // A: N=4 W=1 STEPS=3
    logic a_start, a_mode, a_busy, a_done;
    logic [3:0] a_load, a_q;
    // B: N=4 W=1 STEPS=1
    logic b_start, b_mode, b_busy, b_done;
    logic [3:0] b_load, b_q;
    // C: N=3 W=2 STEPS=1
    logic c_start, c_mode, c_busy, c_done;
    logic [5:0] c_load, c_q;
    // D: N=4 W=4 STEPS=4
    logic d_start, d_mode, d_busy, d_done;
    logic [15:0] d_load, d_q;
    // E: N=4 W=1 STEPS=2
    logic e_start, e_mode, e_busy, e_done;
    logic [3:0] e_load, e_q;

`ifdef XCHG_SNAPSHOT_EN
    logic [3:0]  a_snap, b_snap, e_snap;
    logic [5:0]  c_snap;
    logic [15:0] d_snap;
`endif

    ordered_xchg_bank #(.W(1), .N(4), .STEPS(3)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .mode(a_mode), .load_data(a_load),
        .busy(a_busy), .done(a_done), .q(a_q)
`ifdef XCHG_SNAPSHOT_EN
        , .snap(a_snap)
`endif
    );

    ordered_xchg_bank #(.W(1), .N(4), .STEPS(1)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .load_data(b_load),
        .busy(b_busy), .done(b_done), .q(b_q)
`ifdef XCHG_SNAPSHOT_EN
        , .snap(b_snap)
`endif
    );

    ordered_xchg_bank #(.W(2), .N(3), .STEPS(1)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .mode(c_mode), .load_data(c_load),
        .busy(c_busy), .done(c_done), .q(c_q)
`ifdef XCHG_SNAPSHOT_EN
        , .snap(c_snap)
`endif
    );

    ordered_xchg_bank #(.W(4), .N(4), .STEPS(4)) u_d (
        .clk(clk), .rst(rst), .start(d_start), .mode(d_mode), .load_data(d_load),
        .busy(d_busy), .done(d_done), .q(d_q)
`ifdef XCHG_SNAPSHOT_EN
        , .snap(d_snap)
`endif
    );

    ordered_xchg_bank #(.W(1), .N(4), .STEPS(2)) u_e (
        .clk(clk), .rst(rst), .start(e_start), .mode(e_mode), .load_data(e_load),
        .busy(e_busy), .done(e_done), .q(e_q)
`ifdef XCHG_SNAPSHOT_EN
        , .snap(e_snap)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Continuous-start table for E (STEPS=2, period 4): load per edge, rotate-by-2 results.
    logic [3:0] e_ld_tab [12];
    logic [3:0] e_res_tab [3];

    initial begin
        rst = 1'b1;
        {a_start, b_start, c_start, d_start, e_start} = '0;
        {a_mode, b_mode, c_mode, d_mode, e_mode} = '0;
        a_load = '0; b_load = '0; c_load = '0; d_load = '0; e_load = '0;
        for (int k = 0; k < 12; k++) e_ld_tab[k] = 4'((k * 3 + 1) & 15);
        e_res_tab[0] = 4'b0100;  // 0001 rotated twice
        e_res_tab[1] = 4'b0111;  // 1101 rotated twice
        e_res_tab[2] = 4'b0110;  // 1001 rotated twice

        tick();
        tick();
        check("reset_q",    {28'd0, b_q}, 32'd0);
        check("reset_busy", {31'd0, b_busy}, 32'd0);
        check("reset_done", {31'd0, b_done}, 32'd0);
        rst = 1'b0;
        tick();

        // Rotate, STEPS=1: 0001 -> 1000
        b_load = 4'b0001; b_mode = 1'b0; b_start = 1'b1;
        tick();
        b_start = 1'b0; b_load = 4'b1111;
        check("rot_acc_busy", {31'd0, b_busy}, 32'd1);
        check("rot_acc_done", {31'd0, b_done}, 32'd0);
        check("rot_acc_q",    {28'd0, b_q}, 32'h1);
`ifdef XCHG_SNAPSHOT_EN
        check("snap_acc", {28'd0, b_snap}, 32'h1);
`endif
        tick();
        check("rot_q",    {28'd0, b_q}, 32'h8);
        check("rot_busy", {31'd0, b_busy}, 32'd0);
        check("rot_done", {31'd0, b_done}, 32'd1);
        tick();
        check("rot_done_pulse", {31'd0, b_done}, 32'd0);
        check("rot_idle_busy",  {31'd0, b_busy}, 32'd0);
        check("rot_hold_q",     {28'd0, b_q}, 32'h8);
`ifdef XCHG_SNAPSHOT_EN
        check("snap_hold", {28'd0, b_snap}, 32'h1);
`endif

        // Reset in the second XCHG cycle of a STEPS=3 op
        a_load = 4'b1011; a_mode = 1'b0; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("rst_pre_busy", {31'd0, a_busy}, 32'd1);
        tick();
        #2 rst = 1'b1;
        #1;
        check("rst_async_q",    {28'd0, a_q}, 32'd0);
        check("rst_async_busy", {31'd0, a_busy}, 32'd0);
        check("rst_async_done", {31'd0, a_done}, 32'd0);
        check("rst_b_q",        {28'd0, b_q}, 32'd0);
`ifdef XCHG_SNAPSHOT_EN
        check("snap_reset", {28'd0, b_snap}, 32'd0);
`endif
        tick();
        rst = 1'b0;
        tick();
        check("rst_idle_busy", {31'd0, a_busy}, 32'd0);
        check("rst_idle_q",    {28'd0, a_q}, 32'd0);

        // Fresh STEPS=3 rotate after abort: 0001 -> 1000 -> 0100 -> 0010
        a_load = 4'b0001; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        check("a_step1_q", {28'd0, a_q}, 32'h8);
        tick();
        check("a_step2_q",    {28'd0, a_q}, 32'h4);
        check("a_step2_busy", {31'd0, a_busy}, 32'd1);
        tick();
        check("a_final_q",    {28'd0, a_q}, 32'h2);
        check("a_final_done", {31'd0, a_done}, 32'd1);
        check("a_final_busy", {31'd0, a_busy}, 32'd0);

        // Pair-swap, odd N: {3,2,1} -> {3,1,2}
        c_load = {2'd3, 2'd2, 2'd1}; c_mode = 1'b1; c_start = 1'b1;
        tick();
        c_start = 1'b0;
        tick();
        check("swap_q",    {26'd0, c_q}, {26'd0, 2'd3, 2'd1, 2'd2});
        check("swap_done", {31'd0, c_done}, 32'd1);

        // Multi-step wrap, STEPS=4
        d_load = 16'hDCBA; d_mode = 1'b0; d_start = 1'b1;
        tick();
        d_start = 1'b0;
        check("wrap_acc_q", {16'd0, d_q}, 32'hDCBA);
        tick();
        check("wrap_s1_q", {16'd0, d_q}, 32'hADCB);
        tick();
        check("wrap_s2_q", {16'd0, d_q}, 32'hBADC);
        tick();
        check("wrap_s3_q",    {16'd0, d_q}, 32'hCBAD);
        check("wrap_s3_done", {31'd0, d_done}, 32'd0);
        tick();
        check("wrap_q",    {16'd0, d_q}, 32'hDCBA);
        check("wrap_done", {31'd0, d_done}, 32'd1);
        check("wrap_busy", {31'd0, d_busy}, 32'd0);

        // start held high for 12 edges, STEPS=2: accepts at edges 0, 4, 8
        e_mode = 1'b0; e_start = 1'b1;
        for (int k = 0; k < 12; k++) begin
            e_load = e_ld_tab[k];
            tick();
            case (k % 4)
                0: begin
                    check($sformatf("cont%0d_busy", k), {31'd0, e_busy}, 32'd1);
                    check($sformatf("cont%0d_done", k), {31'd0, e_done}, 32'd0);
                    check($sformatf("cont%0d_q", k), {28'd0, e_q}, {28'd0, e_ld_tab[k]});
                end
                1: begin
                    check($sformatf("cont%0d_busy", k), {31'd0, e_busy}, 32'd1);
                    check($sformatf("cont%0d_done", k), {31'd0, e_done}, 32'd0);
                end
                2: begin
                    check($sformatf("cont%0d_busy", k), {31'd0, e_busy}, 32'd0);
                    check($sformatf("cont%0d_done", k), {31'd0, e_done}, 32'd1);
                    check($sformatf("cont%0d_q", k), {28'd0, e_q}, {28'd0, e_res_tab[k/4]});
                end
                default: begin
                    check($sformatf("cont%0d_busy", k), {31'd0, e_busy}, 32'd0);
                    check($sformatf("cont%0d_done", k), {31'd0, e_done}, 32'd0);
                    check($sformatf("cont%0d_q", k), {28'd0, e_q}, {28'd0, e_res_tab[k/4]});
                end
            endcase
        end
        e_start = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
